sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO, next generation of the team's 32-bit x 8 buffer.
//  Adds configurable width/depth (non-power-of-2 depth), true simultaneous read+write,
//  occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow.
//  Buffers transfers between the APB memory-side driver and downstream consumers.
// PARAMETERS
//  DATA_W     32          data word width in bits
//  DEPTH      8           number of entries, >= 2, any integer
//  AF_THRESH  DEPTH-1     almost_full_o asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  1           almost_empty_o asserted when count <= AE_THRESH (0..DEPTH-1)
//  derived: ADDR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)
// PORTS
//  clk             in   1       clock, all state updates on rising edge
//  rst_n           in   1       reset, asynchronous, active-high
//  wr_en_i         in   1       write request
//  data_i          in   DATA_W  write data
//  full_o          out  1       count == DEPTH
//  almost_full_o   out  1       count >= AF_THRESH
//  rd_en_i         in   1       read request
//  data_o          out  DATA_W  registered read data
//  valid_o         out  1       1-cycle pulse: data_o updated by accepted read
//  empty_o         out  1       count == 0
//  almost_empty_o  out  1       count <= AE_THRESH
//  count_o         out  CNT_W   current occupancy, 0..DEPTH
//  overflow_o      out  1       sticky: write rejected
//  underflow_o     out  1       sticky: read rejected
//  clr_err_i       in   1       clears overflow_o/underflow_o
// BEHAVIOUR
//  - Reset (rst_n=1, async): wr_ptr, rd_ptr, count_o, data_o, valid_o, overflow_o,
//    underflow_o -> 0; empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0.
//    Memory array not reset; reset mid-operation discards all contents immediately.
//  - rd_acc = rd_en_i & ~empty_o.  wr_acc = wr_en_i & (~full_o | rd_acc).
//  - wr_acc: mem[wr_ptr] <= data_i; wr_ptr advances, DEPTH-1 wraps to 0.
//  - rd_acc: data_o <= mem[rd_ptr]; rd_ptr advances with same wrap; valid_o=1 next cycle,
//    else valid_o=0. data_o holds last value when no read accepted.
//  - Latency: word written at edge N is readable (rd_acc) from edge N+1; appears on
//    data_o after that read edge. No fall-through: read on empty never returns data_i.
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//  - Full + rd_en_i + wr_en_i: both accepted, count stays DEPTH.
//  - Empty + rd_en_i + wr_en_i: write accepted, read rejected (underflow set), count=1.
//  - Status flags combinational from count register (no extra latency).
//  - overflow_o set on wr_en_i & ~wr_acc; underflow_o set on rd_en_i & ~rd_acc.
//    Both held until clr_err_i; set wins over clear in the same cycle.
//  - Rejected operations change no pointer, count or memory.
// TESTING
//  1 Reset: assert rst_n mid-cycle -> outputs zero at once; empty_o=1, count_o=0.
//  2 DEPTH=8: write 0x1..0x8 -> full_o=1 after 8th, almost_full_o=1 at count 7; read 8
//    -> data_o 0x1..0x8 in order, valid_o pulse each, empty_o=1.
//  3 Full, write 0xDEAD alone -> overflow_o=1, count stays 8; clr_err_i -> overflow_o=0.
//  4 Full, rd+wr same cycle 0xBEEF -> count=8, data_o=oldest word; 0xBEEF read last.
//  5 Empty, rd+wr 0x55 -> underflow_o=1, count=1, valid_o=0; next read returns 0x55.
//  6 DEPTH=5: 12 writes/reads interleaved across wrap -> order preserved, count exact.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds
// and sticky overflow/underflow flags. Any DEPTH >= 2; registered read data.
module sync_fifo_param #(
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned DEPTH     = 8,
  parameter  int unsigned AF_THRESH = DEPTH - 1,
  parameter  int unsigned AE_THRESH = 1,
  localparam int unsigned ADDR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              almost_full_o,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic              underflow_o,
  input  logic              clr_err_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_acc, wr_acc;

  // Status flags come straight from the count register, no extra latency.
  always_comb begin
    empty_o        = (count_q == '0);
    full_o         = (count_q == CNT_W'(DEPTH));
    almost_full_o  = (count_q >= CNT_W'(AF_THRESH));
    almost_empty_o = (count_q <= CNT_W'(AE_THRESH));
  end

  // A write into a full FIFO is still taken when a read frees a slot the same cycle.
  always_comb begin
    rd_acc = rd_en_i & ~empty_o;
    wr_acc = wr_en_i & (~full_o | rd_acc);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = rd_acc;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
      data_d   = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = (ovf_q & ~clr_err_i) | (wr_en_i & ~wr_acc);
    unf_d = (unf_q & ~clr_err_i) | (rd_en_i & ~rd_acc);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o     = count_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: DEPTH=8 (default thresholds) and DEPTH=5 (AF=3, AE=2)
// instances checked against queue-based reference models.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        wr8, rd8, clr8, full8, af8, empty8, ae8, valid8, ovf8, unf8;
  logic [31:0] din8, dout8;
  logic [3:0]  cnt8;
  logic        wr5, rd5, clr5, full5, af5, empty5, ae5, valid5, ovf5, unf5;
  logic [31:0] din5, dout5;
  logic [2:0]  cnt5;

  sync_fifo_param #(.DATA_W(32), .DEPTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr8), .data_i(din8), .full_o(full8),
    .almost_full_o(af8), .rd_en_i(rd8), .data_o(dout8), .valid_o(valid8),
    .empty_o(empty8), .almost_empty_o(ae8), .count_o(cnt8), .overflow_o(ovf8),
    .underflow_o(unf8), .clr_err_i(clr8));

  sync_fifo_param #(.DATA_W(32), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2)) u_d5 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr5), .data_i(din5), .full_o(full5),
    .almost_full_o(af5), .rd_en_i(rd5), .data_o(dout5), .valid_o(valid5),
    .empty_o(empty5), .almost_empty_o(ae5), .count_o(cnt5), .overflow_o(ovf5),
    .underflow_o(unf5), .clr_err_i(clr5));

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state: queue contents plus last read word and sticky flags.
  logic [31:0] q8[$], q5[$];
  logic [31:0] md8 = '0, md5 = '0;
  bit mv8 = 0, mo8 = 0, mu8 = 0, mv5 = 0, mo5 = 0, mu5 = 0;

  logic [42:0] obs8;
  logic [41:0] obs5;
  assign obs8 = {cnt8, full8, af8, empty8, ae8, valid8, ovf8, unf8, dout8};
  assign obs5 = {cnt5, full5, af5, empty5, ae5, valid5, ovf5, unf5, dout5};

  function automatic logic [42:0] exp8();
    int n = q8.size();
    return {4'(n), n == 8, n >= 7, n == 0, n <= 1, mv8, mo8, mu8, md8};
  endfunction

  function automatic logic [41:0] exp5();
    int n = q5.size();
    return {3'(n), n == 5, n >= 3, n == 0, n <= 2, mv5, mo5, mu5, md5};
  endfunction

  task automatic model_reset();
    q8.delete(); q5.delete();
    md8 = '0; md5 = '0;
    mv8 = 0; mo8 = 0; mu8 = 0; mv5 = 0; mo5 = 0; mu5 = 0;
  endtask

  task automatic step8(input bit wr, input bit rd, input bit clr, input logic [31:0] din);
    bit rok, wok;
    wr8 = wr; rd8 = rd; clr8 = clr; din8 = din;
    rok = rd && (q8.size() != 0);
    wok = wr && ((q8.size() < 8) || rok);
    @(posedge clk); #1;
    mv8 = rok;
    if (rok) md8 = q8.pop_front();
    if (wok) q8.push_back(din);
    if (clr) begin mo8 = 0; mu8 = 0; end
    if (wr && !wok) mo8 = 1;
    if (rd && !rok) mu8 = 1;
    wr8 = 0; rd8 = 0; clr8 = 0;
  endtask

  task automatic step5(input bit wr, input bit rd, input bit clr, input logic [31:0] din);
    bit rok, wok;
    wr5 = wr; rd5 = rd; clr5 = clr; din5 = din;
    rok = rd && (q5.size() != 0);
    wok = wr && ((q5.size() < 5) || rok);
    @(posedge clk); #1;
    mv5 = rok;
    if (rok) md5 = q5.pop_front();
    if (wok) q5.push_back(din);
    if (clr) begin mo5 = 0; mu5 = 0; end
    if (wr && !wok) mo5 = 1;
    if (rd && !rok) mu5 = 1;
    wr5 = 0; rd5 = 0; clr5 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    wr8 = 0; rd8 = 0; clr8 = 0; din8 = '0;
    wr5 = 0; rd5 = 0; clr5 = 0; din5 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_cnt++;
    if (obs8 !== 43'({4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0}))
      $display("FAIL reset_d8: got %h want count0/empty/ae only", obs8);
    else pass_cnt++;
    chk_cnt++;
    if (obs5 !== exp5()) $display("FAIL reset_d5: got %h want %h", obs5, exp5());
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step8(1, 0, 0, 32'hA0 + i);
    step8(0, 1, 0, 0);
    step5(1, 0, 0, 32'h77);
    @(negedge clk) rst_n = 1'b1;
    #1;
    model_reset();
    chk_cnt++;
    if (cnt8 !== 4'd0 || empty8 !== 1'b1 || dout8 !== 32'd0)
      $display("FAIL reset_mid_d8: got cnt=%0d empty=%b data=%h want 0/1/0", cnt8, empty8, dout8);
    else pass_cnt++;
    chk_cnt++;
    if (obs5 !== exp5()) $display("FAIL reset_mid_d5: got %h want %h", obs5, exp5());
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b0;
    step8(0, 1, 0, 0);
    chk_cnt++;
    if (valid8 !== 1'b0 || unf8 !== 1'b1)
      $display("FAIL reset_discard: got valid=%b unf=%b want 0/1", valid8, unf8);
    else pass_cnt++;
    step8(0, 0, 1, 0);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      step8(1, 0, 0, i);
      chk_cnt++;
      if (cnt8 !== 4'(i) || full8 !== (i == 8) || af8 !== (i >= 7))
        $display("FAIL fill_%0d: got cnt=%0d full=%b af=%b want %0d/%b/%b",
                 i, cnt8, full8, af8, i, (i == 8), (i >= 7));
      else pass_cnt++;
    end
    for (int i = 1; i <= 8; i++) begin
      step8(0, 1, 0, 0);
      chk_cnt++;
      if (dout8 !== 32'(i) || valid8 !== 1'b1)
        $display("FAIL drain_%0d: got data=%h valid=%b want %h/1", i, dout8, valid8, i);
      else pass_cnt++;
    end
    chk_cnt++;
    if (empty8 !== 1'b1 || cnt8 !== 4'd0)
      $display("FAIL drain_empty: got empty=%b cnt=%0d want 1/0", empty8, cnt8);
    else pass_cnt++;
    step8(0, 0, 0, 0);
    chk_cnt++;
    if (valid8 !== 1'b0 || dout8 !== 32'd8)
      $display("FAIL valid_pulse: got valid=%b data=%h want 0/8", valid8, dout8);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step8(1, 0, 0, $urandom);
    step8(1, 0, 0, 32'hDEAD);
    chk_cnt++;
    if (ovf8 !== 1'b1 || cnt8 !== 4'd8)
      $display("FAIL overflow_set: got ovf=%b cnt=%0d want 1/8", ovf8, cnt8);
    else pass_cnt++;
    step8(1, 0, 1, 32'hDEAD);
    chk_cnt++;
    if (ovf8 !== 1'b1) $display("FAIL overflow_set_wins: got %b want 1", ovf8);
    else pass_cnt++;
    step8(0, 0, 1, 0);
    chk_cnt++;
    if (ovf8 !== 1'b0) $display("FAIL overflow_clear: got %b want 0", ovf8);
    else pass_cnt++;
    chk_cnt++;
    if (obs8 !== exp8()) $display("FAIL overflow_state: got %h want %h", obs8, exp8());
    else pass_cnt++;
  endtask

  task automatic test_full_rdwr();
    logic [31:0] oldest;
    oldest = q8[0];
    step8(1, 1, 0, 32'hBEEF);
    chk_cnt++;
    if (cnt8 !== 4'd8 || dout8 !== oldest || valid8 !== 1'b1 || ovf8 !== 1'b0)
      $display("FAIL full_rdwr: got cnt=%0d data=%h valid=%b ovf=%b want 8/%h/1/0",
               cnt8, dout8, valid8, ovf8, oldest);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      step8(0, 1, 0, 0);
      chk_cnt++;
      if (obs8 !== exp8()) $display("FAIL full_rdwr_drain_%0d: got %h want %h", i, obs8, exp8());
      else pass_cnt++;
    end
    chk_cnt++;
    if (dout8 !== 32'hBEEF) $display("FAIL full_rdwr_last: got %h want beef", dout8);
    else pass_cnt++;
  endtask

  task automatic test_empty_rdwr();
    step8(1, 1, 0, 32'h55);
    chk_cnt++;
    if (unf8 !== 1'b1 || cnt8 !== 4'd1 || valid8 !== 1'b0)
      $display("FAIL empty_rdwr: got unf=%b cnt=%0d valid=%b want 1/1/0", unf8, cnt8, valid8);
    else pass_cnt++;
    step8(0, 1, 0, 0);
    chk_cnt++;
    if (dout8 !== 32'h55 || valid8 !== 1'b1)
      $display("FAIL empty_rdwr_read: got data=%h valid=%b want 55/1", dout8, valid8);
    else pass_cnt++;
    step8(0, 0, 1, 0);
    chk_cnt++;
    if (unf8 !== 1'b0) $display("FAIL underflow_clear: got %b want 0", unf8);
    else pass_cnt++;
  endtask

  task automatic test_d5_wrap();
    logic [31:0] nxt;
    nxt = 32'h100;
    for (int k = 0; k < 16; k++) begin
      if (k < 12) step5(1, k >= 4, 0, 32'h100 + k);
      else        step5(0, 1, 0, 0);
      chk_cnt++;
      if (obs5 !== exp5()) $display("FAIL d5_wrap_%0d: got %h want %h", k, obs5, exp5());
      else pass_cnt++;
      if (valid5 === 1'b1) begin
        chk_cnt++;
        if (dout5 !== nxt) $display("FAIL d5_order_%0d: got %h want %h", k, dout5, nxt);
        else pass_cnt++;
        nxt++;
      end
    end
    chk_cnt++;
    if (nxt !== 32'h10C || empty5 !== 1'b1)
      $display("FAIL d5_wrap_end: got next=%h empty=%b want 10c/1", nxt, empty5);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int wp = (c < 200) ? 70 : 35;
      int rp = (c < 200) ? 35 : 70;
      step8($urandom_range(99) < wp, $urandom_range(99) < rp, $urandom_range(99) < 5, $urandom);
      chk_cnt++;
      if (obs8 !== exp8()) $display("FAIL rand_d8_%0d: got %h want %h", c, obs8, exp8());
      else pass_cnt++;
      step5($urandom_range(99) < wp, $urandom_range(99) < rp, $urandom_range(99) < 5, $urandom);
      chk_cnt++;
      if (obs5 !== exp5()) $display("FAIL rand_d5_%0d: got %h want %h", c, obs5, exp5());
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rdwr();
    test_empty_rdwr();
    test_d5_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
